// File: rtl/alu24_accum_seq_if.sv
// Bundle between the operand sequencer, its upstream term source, the ALU24A slice
// and the downstream sum consumer. `slave` is the sequencer, `master` the surroundings.
interface alu24_accum_seq_if #(
  parameter int COUNT_W = 8
);
  logic               s_valid;
  logic               s_ready;
  logic [17:0]        s_a;
  logic [17:0]        s_b;
  logic               s_sub;
  logic               s_signed;
  logic               s_last;

  logic [17:0]        MA;
  logic [17:0]        MB;
  logic               SIGNEDIA;
  logic               SIGNEDIB;
  logic [23:0]        CIN;
  logic               OPADDNSUB;
  logic               OPCINSEL;
  logic               CE_ALU;
  logic [23:0]        R;

  logic               m_valid;
  logic               m_ready;
  logic [23:0]        m_sum;
  logic [COUNT_W-1:0] m_count;

  modport slave (
    input  s_valid, s_a, s_b, s_sub, s_signed, s_last, R, m_ready,
    output s_ready, MA, MB, SIGNEDIA, SIGNEDIB, CIN, OPADDNSUB, OPCINSEL, CE_ALU,
           m_valid, m_sum, m_count
  );

  modport master (
    output s_valid, s_a, s_b, s_sub, s_signed, s_last, R, m_ready,
    input  s_ready, MA, MB, SIGNEDIA, SIGNEDIB, CIN, OPADDNSUB, OPCINSEL, CE_ALU,
           m_valid, m_sum, m_count
  );
endinterface

// File: rtl/alu24_accum_seq.sv
// Operand sequencer for the ALU24A slice: feeds one term at a time, folds each
// result back through CIN and emits the 24-bit run sum with a saturating term count.
module alu24_accum_seq #(
  parameter int ALU_LATENCY = 1,
  parameter int COUNT_W     = 8
) (
  input  logic             CLK0,
  input  logic             RST0,
  alu24_accum_seq_if.slave io
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  typedef struct packed {
    logic [17:0] a;
    logic [17:0] b;
    logic        sub;
    logic        sgn;
  } term_t;

  logic [1:0]           state;
  logic [ALU_LATENCY:0] vld_pipe;
  term_t                term_q;
  logic                 last_q;
  logic                 first_q;
  logic                 cinsel_q;
  logic [23:0]          acc;
  logic [COUNT_W-1:0]   cnt;
  logic                 accept;

  assign accept = io.s_valid & io.s_ready;

  // vld_pipe is a one-hot EXEC cycle tracker: the top bit marks the cycle in
  // which R reflects the held operands after the ALU's own register stages.
  always_ff @(posedge CLK0) begin
    if (RST0) begin
      state    <= ST_IDLE;
      vld_pipe <= '0;
      term_q   <= '0;
      last_q   <= 1'b0;
      first_q  <= 1'b1;
      cinsel_q <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            term_q.a   <= io.s_a;
            term_q.b   <= io.s_b;
            term_q.sub <= io.s_sub;
            term_q.sgn <= io.s_signed;
            last_q     <= io.s_last;
            cinsel_q   <= ~first_q;
            vld_pipe   <= (ALU_LATENCY+1)'(1'b1);
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          vld_pipe <= vld_pipe << 1;
          if (vld_pipe[ALU_LATENCY]) begin
            acc     <= io.R;
            first_q <= 1'b0;
            if (~&cnt) cnt <= cnt + 1'b1;
            state   <= last_q ? ST_OUT : ST_IDLE;
          end
        end
        ST_OUT: begin
          if (io.m_ready) begin
            acc     <= '0;
            cnt     <= '0;
            first_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.s_ready   = (state == ST_IDLE) & ~RST0;
  assign io.CE_ALU    = (state == ST_EXEC);
  assign io.m_valid   = (state == ST_OUT);

  assign io.MA        = term_q.a;
  assign io.MB        = term_q.b;
  assign io.SIGNEDIA  = term_q.sgn;
  assign io.SIGNEDIB  = term_q.sgn;
  assign io.OPADDNSUB = term_q.sub;
  assign io.OPCINSEL  = cinsel_q;
  assign io.CIN       = acc;

  assign io.m_sum     = acc;
  assign io.m_count   = cnt;
endmodule

// File: tb/tb_alu24_accum_seq.sv
// Directed bench for alu24_accum_seq with an ALU24A behavioural stand-in and a
// run-level reference model checked every cycle.
module tb_alu24_accum_seq;
  localparam int L    = 2;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic CLK0 = 1'b0;
  logic RST0 = 1'b1;
  always #5 CLK0 = ~CLK0;

  alu24_accum_seq_if #(.COUNT_W(CW)) io ();

  alu24_accum_seq #(.ALU_LATENCY(L), .COUNT_W(CW)) dut (
    .CLK0 (CLK0),
    .RST0 (RST0),
    .io   (io)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [23:0] ext(input logic [17:0] x, input logic s);
    return s ? {{6{x[17]}}, x} : {6'd0, x};
  endfunction

  function automatic logic [23:0] term_val(input logic [17:0] a, input logic [17:0] b,
                                           input logic sub, input logic sgn);
    return sub ? ext(a, sgn) - ext(b, sgn) : ext(a, sgn) + ext(b, sgn);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ALU24A stand-in: L register stages advanced by CE_ALU, pipeline never flushed.
  logic [23:0] alu_comb;
  logic [23:0] alu_q [0:3];
  always_comb begin
    alu_comb = (io.OPCINSEL ? io.CIN : 24'd0) +
               (io.OPADDNSUB ? ext(io.MA, io.SIGNEDIA) - ext(io.MB, io.SIGNEDIB)
                             : ext(io.MA, io.SIGNEDIA) + ext(io.MB, io.SIGNEDIB));
  end
  always @(posedge CLK0) begin
    if (io.CE_ALU) begin
      alu_q[0] <= alu_comb;
      for (int i = 1; i < 4; i++) alu_q[i] <= alu_q[i-1];
    end
  end
  assign io.R = (L == 0) ? alu_comb : alu_q[(L == 0) ? 0 : L-1];

  // Reference model: a run is a list of terms; each term keeps the block busy
  // for L+1 cycles, then the sum is offered until the consumer takes it.
  int          ex_left  = 0;
  bit          out_pend = 1'b0;
  bit          just_rst = 1'b0;
  logic [23:0] run_sum  = '0;
  int          run_n    = 0;
  logic [17:0] t_a = '0, t_b = '0;
  logic        t_sub = 1'b0, t_sgn = 1'b0, t_last = 1'b0;
  logic [23:0] t_val = '0;

  always @(posedge CLK0) begin
    if (RST0) begin
      ex_left  <= 0;
      out_pend <= 1'b0;
      run_sum  <= '0;
      run_n    <= 0;
      just_rst <= 1'b1;
    end else begin
      just_rst <= 1'b0;
      if (ex_left == 0 && !out_pend) begin
        if (io.s_valid) begin
          ex_left <= L + 1;
          t_a     <= io.s_a;
          t_b     <= io.s_b;
          t_sub   <= io.s_sub;
          t_sgn   <= io.s_signed;
          t_last  <= io.s_last;
          t_val   <= term_val(io.s_a, io.s_b, io.s_sub, io.s_signed);
        end
      end else if (ex_left != 0) begin
        ex_left <= ex_left - 1;
        if (ex_left == 1) begin
          run_sum  <= run_sum + t_val;
          run_n    <= run_n + 1;
          out_pend <= t_last;
        end
      end else if (io.m_ready) begin
        out_pend <= 1'b0;
        run_sum  <= '0;
        run_n    <= 0;
      end
    end
  end

  always @(negedge CLK0) begin
    chk("s_ready", io.s_ready, (ex_left == 0 && !out_pend && !RST0));
    chk("ce_alu",  io.CE_ALU,  (ex_left != 0));
    chk("m_valid", io.m_valid, out_pend);
    if (out_pend) begin
      chk("m_sum",   io.m_sum,   run_sum);
      chk("m_count", io.m_count, (run_n > MAXC) ? MAXC : run_n);
    end
    if (ex_left != 0) begin
      chk("ma",       io.MA,        t_a);
      chk("mb",       io.MB,        t_b);
      chk("cin",      io.CIN,       run_sum);
      chk("addnsub",  io.OPADDNSUB, t_sub);
      chk("signedia", io.SIGNEDIA,  t_sgn);
      chk("signedib", io.SIGNEDIB,  t_sgn);
      chk("cinsel",   io.OPCINSEL,  (run_n != 0));
    end
    if (just_rst) begin
      chk("rst_ma",   io.MA,      0);
      chk("rst_mb",   io.MB,      0);
      chk("rst_cin",  io.CIN,     0);
      chk("rst_sum",  io.m_sum,   0);
      chk("rst_cnt",  io.m_count, 0);
      chk("rst_ctrl", {io.SIGNEDIA, io.SIGNEDIB, io.OPADDNSUB, io.OPCINSEL}, 0);
    end
  end

  task automatic send(input logic [17:0] a, input logic [17:0] b,
                      input logic sub, input logic sgn, input logic last);
    bit ok = 1'b0;
    io.s_valid  = 1'b1;
    io.s_a      = a;
    io.s_b      = b;
    io.s_sub    = sub;
    io.s_signed = sgn;
    io.s_last   = last;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge CLK0);
      ok = io.s_ready;
      @(posedge CLK0);
      #1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: s_ready never seen for a=0x%0h b=0x%0h", a, b);
    end
  endtask

  task automatic wait_out(input logic [23:0] es, input int ec, input int hold, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge CLK0);
      seen = io.m_valid;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s_timeout: m_valid never seen, expected sum 0x%0h", nm, es);
    end else begin
      chk({nm, "_sum"},   io.m_sum,   es);
      chk({nm, "_cnt"},   io.m_count, ec);
      chk({nm, "_model"}, run_sum,    es);
    end
    // junk terms offered while the sum is pending must be ignored
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK0);
      #1;
      io.s_valid = 1'b1;
      io.s_a     = 18'($urandom);
      io.s_b     = 18'($urandom);
      io.s_last  = 1'($urandom);
    end
    if (hold > 0) begin
      @(negedge CLK0);
      chk({nm, "_hold_sum"}, io.m_sum,   es);
      chk({nm, "_hold_cnt"}, io.m_count, ec);
    end
    @(posedge CLK0);
    #1;
    io.s_valid = 1'b0;
    io.m_ready = 1'b1;
    @(posedge CLK0);
    #1;
    io.m_ready = 1'b0;
  endtask

  initial begin
    io.s_valid  = 1'b0;
    io.s_a      = '0;
    io.s_b      = '0;
    io.s_sub    = 1'b0;
    io.s_signed = 1'b0;
    io.s_last   = 1'b0;
    io.m_ready  = 1'b0;
    repeat (3) @(posedge CLK0);
    #1;
    RST0 = 1'b0;

    // single term
    send(18'd5, 18'd3, 1'b0, 1'b0, 1'b1);
    wait_out(24'h000008, 1, 0, "single");

    // mixed signedness, back-to-back terms
    send(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1, 1'b0);
    send(18'd100,   18'd50,    1'b1, 1'b1, 1'b0);
    send(18'h1FFFF, 18'd1,     1'b0, 1'b0, 1'b1);
    wait_out(24'h020030, 3, 0, "mixed");

    // 24-bit wrap
    for (int i = 0; i < 33; i++) send(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, i == 32);
    wait_out(24'h07FFBE, 33, 0, "wrap");

    // output backpressure, then a fresh run starts from zero
    send(18'd10, 18'd20, 1'b0, 1'b0, 1'b1);
    wait_out(24'h00001E, 1, 5, "bp");
    send(18'd1, 18'd1, 1'b0, 1'b0, 1'b1);
    wait_out(24'h000002, 1, 0, "after_bp");

    // negative signed operand then unsigned subtract
    send(18'h20000, 18'd0, 1'b0, 1'b1, 1'b0);
    send(18'h20000, 18'd1, 1'b1, 1'b0, 1'b1);
    wait_out(24'hFFFFFF, 2, 0, "neg");

    // reset during EXEC of the second term
    send(18'd1, 18'd1, 1'b0, 1'b0, 1'b0);
    send(18'd2, 18'd2, 1'b0, 1'b0, 1'b0);
    io.s_valid = 1'b0;
    @(posedge CLK0);
    #1;
    RST0 = 1'b1;
    @(posedge CLK0);
    #1;
    RST0 = 1'b0;
    send(18'd7, 18'd2, 1'b0, 1'b0, 1'b1);
    wait_out(24'h000009, 1, 0, "post_rst");

    // count saturation
    for (int i = 0; i < 257; i++) send(18'd1, 18'd0, 1'b0, 1'b0, i == 256);
    wait_out(24'h000101, MAXC, 0, "sat");

    repeat (3) @(posedge CLK0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu24_accum_seq.md
# alu24_accum_seq

Operand sequencer and accumulator that sits directly upstream of the ECP5 ALU24A 24-bit add/sub slice and also consumes its R output. It accepts a stream of 18-bit operand pairs over a valid/ready handshake and drives MA/MB/CIN/opcode into the ALU. Each result is fed back through CIN, so a run of terms is accumulated into a 24-bit sum. The sum is emitted on a valid/ready output when the last term of the run has been processed.

## Interface

**Parameters**

- `ALU_LATENCY`, default 1: number of registered stages configured in the attached ALU24A (0..3, counting opcode and output registers).
- `COUNT_W`, default 8: width of the term counter.

**Ports**

- `CLK0` in 1: single clock.
- `RST0` in 1: synchronous, active-high reset.
- `s_valid` in 1: input term valid.
- `s_ready` out 1: block can accept a term.
- `s_a` in 18: operand A.
- `s_b` in 18: operand B.
- `s_sub` in 1: 1 = A − B, 0 = A + B.
- `s_signed` in 1: sign-extend A and B; 0 = zero-extend.
- `s_last` in 1: final term of the run.
- `MA` out 18: ALU operand A.
- `MB` out 18: ALU operand B.
- `SIGNEDIA` out 1: ALU signed-A control.
- `SIGNEDIB` out 1: ALU signed-B control.
- `CIN` out 24: feedback accumulator value.
- `OPADDNSUB` out 1: ALU add/subtract select.
- `OPCINSEL` out 1: ALU CIN select.
- `CE_ALU` out 1: ALU register clock enable.
- `R` in 24: ALU result.
- `m_valid` out 1: sum valid.
- `m_ready` in 1: sum consumed.
- `m_sum` out 24: accumulated sum.
- `m_count` out COUNT_W: terms in the run, saturating.

## Operation

- **States:** IDLE, EXEC, OUT. Reset state is IDLE.
- **Output decode:** `s_ready = (state==IDLE) & ~RST0`. `CE_ALU = (state==EXEC)`. `m_valid = (state==OUT)`.

**IDLE**
- On `s_valid & s_ready`, register `s_a` → MA, `s_b` → MB, `s_signed` → SIGNEDIA and SIGNEDIB, `s_sub` → OPADDNSUB, and latch `s_last`.
- Set `OPCINSEL = 0` if this is the first term of the run, else 1.
- Load the EXEC cycle counter with 0 and go to EXEC.

**EXEC**
- Lasts exactly `ALU_LATENCY+1` cycles. MA/MB/CIN/opcodes are held stable throughout.
- On the final EXEC cycle:
  - Capture `R` → acc.
  - Increment `m_count`, saturating at 2^COUNT_W−1.
  - Clear the first-term flag.
- If the latched last flag is set, go to OUT. Otherwise go to IDLE.

**OUT**
- `m_sum = acc`; `m_sum` and `m_count` are held stable.
- On `m_ready`: clear acc and `m_count`, set the first-term flag, go to IDLE.
- `s_valid` is ignored in this state.

**Arithmetic and feedback**
- `CIN` is driven from acc at all times. acc is 0 for the first term, so the first result = ext(A) ± ext(B).
- Subsequent results = acc + ext(A) ± ext(B), mod 2^24. Wrap-around is silent; no overflow flag.
- `s_signed` is applied per term; terms with mixed signedness are allowed within a run.

**Reset**
- While `RST0` is high (including mid-EXEC or mid-OUT), at the next edge:
  - state = IDLE, first-term flag = 1.
  - MA, MB, CIN, acc, `m_count`, `m_sum` = 0.
  - SIGNEDIA, SIGNEDIB, OPADDNSUB, OPCINSEL = 0.
- The ALU's own pipeline is not flushed. The next run re-fills it during EXEC, so stale contents are harmless.

## Timing

- **Accept:** the term is taken at edge e0 (`s_valid & s_ready` high in cycle 0).
- **EXEC:** occupies cycles 1..`ALU_LATENCY+1`; acc is captured at edge e(`ALU_LATENCY+1`).
- **Throughput:** one term per `ALU_LATENCY+2` cycles. `s_ready` returns high in the cycle after capture for non-last terms.
- **Run completion:** `m_valid` rises in the cycle after the last capture. Earliest next accept is the cycle after `m_valid & m_ready`.
- **Reset values:**
  - `s_ready` = 0 while `RST0` is high, 1 in the first cycle after.
  - `m_valid`, `CE_ALU`, and all data outputs = 0.

## Test plan

1. **Single term, no latency.** `ALU_LATENCY=0`; `a=5, b=3`, add, last → capture at e1, `m_valid` high in cycle 2, `m_sum=0x000008`, `m_count=1`.
2. **Signed/unsigned run, latency 2.** `ALU_LATENCY=2`; terms (−1)+(−1) signed, then 100−50 signed, then 0x1FFFF+1 unsigned with last → `m_sum=0x020030`, `m_count=3`; `s_ready` re-asserts every 4 cycles under continuous `s_valid`.
3. **24-bit wrap.** Unsigned 0x3FFFF+0x3FFFF repeated 33 times, last on the 33rd → `m_sum=0x07FFBE`, `m_count=33`.
4. **Output backpressure.** Hold `m_ready` low 5 cycles while in OUT → `m_valid`, `m_sum`, `m_count` stable; `s_ready=0`; `s_valid` ignored. Raise `m_ready` → IDLE next cycle, and the next run starts from acc=0.
5. **Reset mid-run.** Pulse `RST0` during EXEC of the second term → all outputs 0 the next cycle. A following single term 7+2 gives `m_sum=9`, `m_count=1`.
6. **Counter saturation.** `COUNT_W=2`; five terms of 1+0, last on the fifth → `m_sum=5`, `m_count=3`.
